// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline control types and constants
// Exports REG_ADDR_W, the hazard-unit state encoding and the multiply
// latency default used by hazard_control_unit.
package core_pkg;

    localparam int REG_ADDR_W      = 3;
    localparam int MUL_LATENCY_DEF = 4;
    localparam int MUL_CNT_W       = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hcu_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit saturating up-counter with enable
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears count
//   en    : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / branch / multiply pipeline sequencing
// Ports:
//   clk_i, rst_n_i          : clock and asynchronous active-low reset
//   id_*                    : source-register usage and multiply flag of the ID instruction
//   ex_*                    : load / write-back info of the EX instruction
//   branch_taken_i          : branch resolved taken in EX
//   pc_en_o, if_id_en_o     : front-end advance enables
//   if_id_flush_o           : IF-ID becomes a NOP
//   id_ex_bubble_o          : ID-EX loads a NOP
//   ex_hold_o               : EX-MEM holds while the multiplier runs
//   mul_start_o, mul_busy_o : multiplier start pulse / occupancy
//   stall_cycles_o          : saturating count of cycles with pc_en_o=0
module hazard_control_unit
    import core_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int PERF_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_is_mul_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_reg_write_i,
    input  logic [REG_ADDR_W-1:0] ex_write_addr_i,
    input  logic                  branch_taken_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic                  ex_hold_o,
    output logic                  mul_start_o,
    output logic                  mul_busy_o,
    output logic [PERF_W-1:0]     stall_cycles_o
);

    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LATENCY - 1);
    localparam logic [MUL_CNT_W-1:0] CNT_ONE  = MUL_CNT_W'(1);

    hcu_state_t           state;
    logic [MUL_CNT_W-1:0] mul_cnt;
    logic                 load_use;
    logic                 mul_go;
    logic                 stall_en;

    // r0 is deliberately not excluded: a load to r0 still stalls.
    assign load_use = ex_is_load_i & ex_reg_write_i &
                      ((id_uses_rs_i & (id_rs_addr_i == ex_write_addr_i)) |
                       (id_uses_rt_i & (id_rt_addr_i == ex_write_addr_i)));

    // A taken branch squashes the ID instruction, and a load-use stall keeps
    // it in ID, so a multiply only launches when neither applies.
    assign mul_go = (state == RUN) & ~branch_taken_i & ~load_use & id_is_mul_i;

    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_hold_o      = 1'b0;
        mul_start_o    = 1'b0;
        mul_busy_o     = 1'b0;
        if (state == MUL_WAIT) begin
            // EX owns the multiply; branch and load-use inputs are ignored.
            mul_busy_o = 1'b1;
            pc_en_o    = 1'b0;
            if_id_en_o = 1'b0;
            ex_hold_o  = (mul_cnt != CNT_ONE);
        end else if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (load_use) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (id_is_mul_i) begin
            mul_start_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else if (state == MUL_WAIT) begin
            mul_cnt <= mul_cnt - CNT_ONE;
            // Last count: product retires to MEM at this edge.
            if (mul_cnt == CNT_ONE) begin
                state <= RUN;
            end
        end else if (mul_go) begin
            state   <= MUL_WAIT;
            mul_cnt <= MUL_LOAD;
        end
    end

    assign stall_en = ~pc_en_o;

    sat_counter #(
        .W (PERF_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (stall_en),
        .count (stall_cycles_o)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

    localparam int ML  = 4;
    localparam int PW  = 4;
    localparam int SAT = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    id_rs_addr = '0;
    logic [2:0]    id_rt_addr = '0;
    logic          id_uses_rs = 1'b0;
    logic          id_uses_rt = 1'b0;
    logic          id_is_mul = 1'b0;
    logic          ex_is_load = 1'b0;
    logic          ex_reg_write = 1'b0;
    logic [2:0]    ex_write_addr = '0;
    logic          branch_taken = 1'b0;
    logic          pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, mul_start, mul_busy;
    logic [PW-1:0] stall_cycles;

    hazard_control_unit #(
        .MUL_LATENCY (ML),
        .PERF_W      (PW)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .id_rs_addr_i    (id_rs_addr),
        .id_rt_addr_i    (id_rt_addr),
        .id_uses_rs_i    (id_uses_rs),
        .id_uses_rt_i    (id_uses_rt),
        .id_is_mul_i     (id_is_mul),
        .ex_is_load_i    (ex_is_load),
        .ex_reg_write_i  (ex_reg_write),
        .ex_write_addr_i (ex_write_addr),
        .branch_taken_i  (branch_taken),
        .pc_en_o         (pc_en),
        .if_id_en_o      (if_id_en),
        .if_id_flush_o   (if_id_flush),
        .id_ex_bubble_o  (id_ex_bubble),
        .ex_hold_o       (ex_hold),
        .mul_start_o     (mul_start),
        .mul_busy_o      (mul_busy),
        .stall_cycles_o  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic       mul;
        logic       ld;
        logic       rw;
        logic [2:0] wa;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic          pc;
        logic          ifid;
        logic          flush;
        logic          bub;
        logic          hold;
        logic          start;
        logic          busy;
        logic [PW-1:0] stall;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: cycles of front-end stall still owed to an in-flight
    // multiply, and total stall cycles since reset.
    int   mul_left  = 0;
    int   stall_tot = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic [2:0] rs, input logic urs, input logic [2:0] rt,
                                 input logic urt, input logic ld, input logic rw,
                                 input logic [2:0] wa, input logic mul, input logic br);
        stim_t s;
        s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
        s.ld = ld; s.rw = rw; s.wa = wa; s.mul = mul; s.br = br;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endfunction

    task automatic drive(input stim_t s);
        id_rs_addr    = s.rs;
        id_rt_addr    = s.rt;
        id_uses_rs    = s.urs;
        id_uses_rt    = s.urt;
        id_is_mul     = s.mul;
        ex_is_load    = s.ld;
        ex_reg_write  = s.rw;
        ex_write_addr = s.wa;
        branch_taken  = s.br;
    endtask

    // Issue one cycle of stimulus and push what the model says must appear.
    task automatic apply(input stim_t s);
        exp_t x;
        logic lu;
        @(posedge clk);
        #1;
        drive(s);
        lu = s.ld && s.rw && ((s.urs && s.rs == s.wa) || (s.urt && s.rt == s.wa));
        x = '0;
        x.stall = PW'(stall_tot);
        if (mul_left > 0) begin
            x.busy = 1'b1;
            x.hold = (mul_left > 1);
            mul_left--;
        end else if (s.br) begin
            x.pc = 1'b1; x.ifid = 1'b1; x.flush = 1'b1; x.bub = 1'b1;
        end else if (lu) begin
            x.bub = 1'b1;
        end else if (s.mul) begin
            x.pc = 1'b1; x.ifid = 1'b1; x.start = 1'b1;
            mul_left = ML - 1;
        end else begin
            x.pc = 1'b1; x.ifid = 1'b1;
        end
        if (!x.pc && stall_tot < SAT) stall_tot++;
        q.push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(idle());
        rst_n = 1'b0;
        #2;
        check("rst_pc_en", pc_en, 1);
        check("rst_if_id_en", if_id_en, 1);
        check("rst_others", {if_id_flush, id_ex_bubble, ex_hold, mul_start, mul_busy}, 0);
        check("rst_stall", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mul_left  = 0;
        stall_tot = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_en", pc_en, e.pc);
            check("if_id_en", if_id_en, e.ifid);
            check("if_id_flush", if_id_flush, e.flush);
            check("id_ex_bubble", id_ex_bubble, e.bub);
            check("ex_hold", ex_hold, e.hold);
            check("mul_start", mul_start, e.start);
            check("mul_busy", mul_busy, e.busy);
            check("stall_cycles", stall_cycles, e.stall);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        do_reset();

        // Load-use on rs, then the same compare with rs unused.
        apply(mk(3'd3, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
        apply(idle());
        apply(mk(3'd3, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
        apply(mk(3'd6, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0));
        apply(idle());

        // Single multiply.
        apply(mk(3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
        repeat (4) apply(idle());

        // Branch wins over load-use and multiply.
        apply(mk(3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1));
        apply(idle());

        // Back-to-back multiplies: ID keeps a mul presented throughout.
        do_reset();
        repeat (8) apply(mk(3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
        apply(idle());

        // Reset asserted mid-multiply with mul_cnt = 2.
        apply(mk(3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
        apply(idle());
        @(posedge clk);
        #1;
        drive(idle());
        check("pre_rst_busy", mul_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", mul_busy, 0);
        check("async_hold", ex_hold, 0);
        check("async_pc_en", pc_en, 1);
        check("async_stall", stall_cycles, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mul_left  = 0;
        stall_tot = 0;

        // Saturation: 20 consecutive load-use stalls on rt.
        repeat (20) apply(mk(3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0));
        apply(idle());

        // Random traffic with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 100; i++) begin
                s.rs  = 3'($urandom_range(0, 3));
                s.rt  = 3'($urandom_range(0, 3));
                s.wa  = 3'($urandom_range(0, 3));
                s.urs = 1'($urandom);
                s.urt = 1'($urandom);
                s.ld  = ($urandom_range(0, 2) == 0);
                s.rw  = ($urandom_range(0, 3) != 0);
                s.mul = ($urandom_range(0, 4) == 0);
                s.br  = ($urandom_range(0, 5) == 0);
                apply(s);
            end
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage core. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
- load-use stalls
- taken-branch flushes
- multi-cycle multiply occupancy of EX

It drives the PC/IF-ID enables, the ID-EX bubble, the IF-ID flush, the EX hold and the multiplier start. It also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LATENCY, 4, EX cycles a multiply occupies (legal 2..15)
PERF_W, 16, width of the stall-cycle counter

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
id_rs_addr_i  in  3  rs field of the instruction in ID
id_rt_addr_i  in  3  rt field of the instruction in ID
id_uses_rs_i  in  1  ID instruction reads rs
id_uses_rt_i  in  1  ID instruction reads rt
id_is_mul_i  in  1  ID instruction is a multiply
ex_is_load_i  in  1  EX instruction is a load
ex_reg_write_i  in  1  EX instruction writes a register
ex_write_addr_i  in  3  EX destination register
branch_taken_i  in  1  branch resolved taken in EX this cycle
pc_en_o  out  1  PC update enable
if_id_en_o  out  1  IF-ID register load enable
if_id_flush_o  out  1  IF-ID becomes a NOP at next edge
id_ex_bubble_o  out  1  ID-EX loads a NOP at next edge
ex_hold_o  out  1  EX-MEM holds, EX operands frozen
mul_start_o  out  1  one-cycle multiplier start pulse
mul_busy_o  out  1  multiply in progress
stall_cycles_o  out  PERF_W  count of cycles with pc_en_o=0

Behaviour:
- FSM states: RUN, MUL_WAIT. Register mul_cnt is 4 bits. stall_cycles_o is registered.
- Reset (asynchronous, while rst_n_i=0):
  - state=RUN, mul_cnt=0, stall_cycles_o=0.
  - Combinational outputs take their RUN values for the current inputs.
  - Reset asserted mid-multiply aborts the multiply immediately: mul_busy_o=0 and ex_hold_o=0 in the same cycle.
- Load-use hazard (lu) = ex_is_load_i & ex_reg_write_i & ((id_uses_rs_i & id_rs_addr_i==ex_write_addr_i) | (id_uses_rt_i & id_rt_addr_i==ex_write_addr_i)).
  - Register 0 is not special; matches on r0 stall.
- RUN, priority highest first:
  1. branch_taken_i: if_id_flush_o=1, id_ex_bubble_o=1, pc_en_o=1, if_id_en_o=1. lu and id_is_mul_i are ignored because the ID instruction is squashed.
  2. lu: pc_en_o=0, if_id_en_o=0, id_ex_bubble_o=1. This lasts exactly one cycle, since the load then leaves EX. A mul waiting in ID is not started.
  3. id_is_mul_i: mul_start_o=1, normal advance, next state=MUL_WAIT, mul_cnt<=MUL_LATENCY-1.
  4. Otherwise: pc_en_o=1, if_id_en_o=1, all other outputs 0.
- MUL_WAIT:
  - Outputs: mul_busy_o=1, pc_en_o=0, if_id_en_o=0, id_ex_bubble_o=0.
  - ex_hold_o=1 while mul_cnt!=1. mul_cnt decrements each cycle.
  - When mul_cnt==1: ex_hold_o=0, the product retires to MEM at the edge, next state=RUN.
  - branch_taken_i and lu are ignored, because EX holds the multiply.
  - Total pc_en_o=0 cycles per multiply = MUL_LATENCY-1.
- Back-to-back: a mul in ID on the first RUN cycle after MUL_WAIT starts immediately, with no idle cycle.
- stall_cycles_o increments on every cycle with pc_en_o=0 and saturates at all-ones, with no wrap.
- Latency: all hazard responses are combinational in the detecting cycle. There is no registered output other than stall_cycles_o.

Decomposition:
- Shared package core_pkg:
  - REG_ADDR_W=3
  - state enum {RUN, MUL_WAIT}
  - MUL_LATENCY default
- One sub-module: sat_counter (PERF_W-wide saturating incrementer with enable, async active-low reset), used for stall_cycles_o.
- The hazard compare stays inline.

Test Plan:
- Load r3 in EX, ID add reads rs=r3 -> one cycle pc_en_o=0, if_id_en_o=0, id_ex_bubble_o=1; next cycle all normal. stall_cycles_o=1. Same compare with id_uses_rs_i=0 -> no stall.
- ID mul, MUL_LATENCY=4 -> mul_start_o pulse. Then 3 cycles of mul_busy_o=1, pc_en_o=0, with ex_hold_o=1,1,0. Back to RUN; stall_cycles_o=3.
- branch_taken_i=1 in the same cycle as lu and id_is_mul_i -> flush+bubble only, no stall, no mul_start_o, state stays RUN.
- Two muls back-to-back -> second mul_start_o on the first RUN cycle after the first completes. stall_cycles_o=6.
- rst_n_i low for one cycle during MUL_WAIT (mul_cnt=2) -> asynchronous return to RUN, mul_busy_o=0 immediately, stall_cycles_o=0.
- Force stall_cycles_o near saturation (PERF_W=4, 15 stall cycles) -> holds at 15 on further stalls.
